// File: rtl/wvlt_postbuf_pkg.sv
`default_nettype none
// wvlt_postbuf_pkg -- shared types and helpers for the multi-level wavelet post-buffer. Rev 1.0
package wvlt_postbuf_pkg;

  localparam int unsigned PB_W_DAT = 16;

  typedef enum logic [1:0] {
    PB_IDLE = 2'd0,
    PB_RD_L = 2'd1,
    PB_RD_H = 2'd2,
    PB_OUT  = 2'd3
  } t_pb_state;

  typedef struct packed {
    logic [PB_W_DAT-1:0] l;
    logic [PB_W_DAT-1:0] h;
  } t_wvlt_pair;

  function automatic int unsigned pb_stride(input int unsigned lvl);
    return 32'd1 << lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wvlt_sdp_ram.sv
`default_nettype none
// wvlt_sdp_ram -- inferred simple dual-port RAM, registered read, 1-cycle latency. Rev 1.0
module wvlt_sdp_ram #(
  parameter  int pW_DAT = 16,
  parameter  int pWORDS = 256,
  localparam int pADR   = $clog2(pWORDS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [pADR-1:0]   i_waddr,
  input  logic [pW_DAT-1:0] i_wdat,
  input  logic [pADR-1:0]   i_raddr,
  output logic [pW_DAT-1:0] o_rdat
);

  logic [pW_DAT-1:0] r_mem [pWORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
    o_rdat <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/wvlt_postbuf_ml.sv
`default_nettype none
// wvlt_postbuf_ml -- multi-level wavelet post-buffer returning (base, base+2^level) pairs. Rev 1.0
module wvlt_postbuf_ml
  import wvlt_postbuf_pkg::*;
#(
  parameter  int pW_DAT     = 16,
  parameter  int pWORDS_DAT = 256,
  parameter  int pLEVELS    = 4,
  localparam int pADR_DAT   = $clog2(pWORDS_DAT),
  localparam int pW_LVL     = (pLEVELS > 1) ? $clog2(pLEVELS) : 1
) (
  input  logic                iclk,
  input  logic                irst_n,
  input  logic                iclk_wr,
  input  logic                iena,
  input  logic [pW_DAT-1:0]   idat,
  input  logic                iclk_rd,
  input  logic                ireq,
  input  logic [pW_LVL-1:0]   ilevel,
  input  logic                iclr,
  output logic                oclk_ena,
  output logic                oena,
  output logic [pW_DAT-1:0]   odat_l,
  output logic [pW_DAT-1:0]   odat_h,
  output logic [pADR_DAT:0]   oavail,
  output logic                oovf,
  output logic                ounf,
  output logic                ocoll
);

  typedef struct packed {
    logic [pW_DAT-1:0] l;
    logic [pW_DAT-1:0] h;
  } t_pair;

  localparam logic [pADR_DAT:0] c_FULL = (pADR_DAT+1)'(pWORDS_DAT);

  t_pb_state             r_state, w_state_nxt;
  logic [pADR_DAT-1:0]   r_wr_ptr, r_base;
  logic [pADR_DAT:0]     r_avail, w_avail_nxt;
  logic [pW_LVL-1:0]     r_lvl, w_lvl;
  logic                  r_req_q, r_bad, r_ovf, r_unf, r_coll;
  logic [pW_DAT-1:0]     r_l;
  t_pair                 r_hold, w_pair;
  logic                  r_hold_ena;
  logic [pW_DAT-1:0]     w_rdat;
  logic [pADR_DAT:0]     w_stride, w_two_s;
  logic [pADR_DAT-1:0]   w_addr_h, w_raddr;
  logic                  w_full, w_wr_en, w_wr_drop;
  logic                  w_start, w_unf_now, w_coll_now, w_pulse, w_retire;

  // A strobe on the same cycle as the ireq rising edge must already see the new level.
  assign w_lvl    = (ireq && !r_req_q) ? ilevel : r_lvl;
  assign w_stride = (pADR_DAT+1)'(pb_stride(32'(w_lvl)));
  assign w_two_s  = w_stride << 1;
  assign w_addr_h = r_base + w_stride[pADR_DAT-1:0];

  assign w_full     = (r_avail == c_FULL);
  assign w_wr_en    = iclk_wr && iena && !w_full;
  assign w_wr_drop  = iclk_wr && iena && w_full;
  assign w_start    = (r_state == PB_IDLE) && iclk_rd && ireq;
  assign w_unf_now  = w_start && (r_avail <= w_stride);
  assign w_coll_now = iclk_rd && (r_state != PB_IDLE);
  assign w_pulse    = (r_state == PB_OUT) && ireq;
  assign w_retire   = w_pulse && !r_bad;
  assign w_raddr    = (r_state == PB_RD_H) ? w_addr_h : r_base;

  wvlt_sdp_ram #(
    .pW_DAT (pW_DAT),
    .pWORDS (pWORDS_DAT)
  ) u_ram (
    .i_clk   (iclk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdat  (idat),
    .i_raddr (w_raddr),
    .o_rdat  (w_rdat)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (!ireq) begin
      w_state_nxt = PB_IDLE;
    end else begin
      case (r_state)
        PB_IDLE: if (iclk_rd) w_state_nxt = PB_RD_L;
        PB_RD_L: w_state_nxt = PB_RD_H;
        PB_RD_H: w_state_nxt = PB_OUT;
        PB_OUT:  w_state_nxt = PB_IDLE;
        default: w_state_nxt = PB_IDLE;
      endcase
    end
  end

  // A pair passing the S+1 check can still retire more than was written; floor at zero.
  always_comb begin
    w_avail_nxt = r_avail + {{pADR_DAT{1'b0}}, w_wr_en};
    if (w_retire) begin
      w_avail_nxt = (w_avail_nxt > w_two_s) ? (w_avail_nxt - w_two_s) : '0;
    end
    if (!ireq && !iena) begin
      w_avail_nxt = '0;
    end
  end

  always_comb begin
    w_pair = '0;
    if (!r_bad) begin
      w_pair.l = r_l;
      w_pair.h = w_rdat;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state    <= PB_IDLE;
      r_wr_ptr   <= '0;
      r_base     <= '0;
      r_avail    <= '0;
      r_lvl      <= '0;
      r_req_q    <= 1'b0;
      r_bad      <= 1'b0;
      r_l        <= '0;
      r_hold     <= '0;
      r_hold_ena <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_coll     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req_q <= ireq;
      r_avail <= w_avail_nxt;
      if (ireq && !r_req_q) r_lvl <= ilevel;

      if (!iena)        r_wr_ptr <= '0;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + pADR_DAT'(1);

      if (!ireq)         r_base <= '0;
      else if (w_retire) r_base <= r_base + w_two_s[pADR_DAT-1:0];

      if (w_start)              r_bad <= w_unf_now;
      if (r_state == PB_RD_H)   r_l   <= w_rdat;

      if (w_pulse) begin
        r_hold     <= w_pair;
        r_hold_ena <= !r_bad;
      end

      if (iclr)           r_ovf <= 1'b0;
      else if (w_wr_drop) r_ovf <= 1'b1;
      if (iclr)           r_unf <= 1'b0;
      else if (w_unf_now) r_unf <= 1'b1;
      if (iclr)            r_coll <= 1'b0;
      else if (w_coll_now) r_coll <= 1'b1;
    end
  end

  // The pair is presented live during OUT and held from then on.
  assign oclk_ena = w_pulse;
  assign oena     = w_pulse ? !r_bad   : r_hold_ena;
  assign odat_l   = w_pulse ? w_pair.l : r_hold.l;
  assign odat_h   = w_pulse ? w_pair.h : r_hold.h;
  assign oavail   = r_avail;
  assign oovf     = r_ovf;
  assign ounf     = r_unf;
  assign ocoll    = r_coll;

endmodule
`default_nettype wire

// File: tb/tb_wvlt_postbuf_ml.sv
`default_nettype none
// tb_wvlt_postbuf_ml -- randomized bench against a frame-level model of the post-buffer.
module tb_wvlt_postbuf_ml;
  import wvlt_postbuf_pkg::*;

  localparam int W = 16;
  localparam int D = 256;

  logic         clk = 1'b0;
  logic         irst_n, iclk_wr, iena, iclk_rd, ireq, iclr;
  logic [W-1:0] idat;
  logic [1:0]   ilevel;
  logic         oclk_ena, oena, oovf, ounf, ocoll;
  logic [W-1:0] odat_l, odat_h;
  logic [8:0]   oavail;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_mem [D];
  int   m_wr, m_base, m_avail;
  logic m_ovf, m_unf, m_coll;

  always #4 clk = ~clk;

  wvlt_postbuf_ml #(.pW_DAT(W), .pWORDS_DAT(D), .pLEVELS(4)) dut (
    .iclk(clk), .irst_n(irst_n), .iclk_wr(iclk_wr), .iena(iena), .idat(idat),
    .iclk_rd(iclk_rd), .ireq(ireq), .ilevel(ilevel), .iclr(iclr),
    .oclk_ena(oclk_ena), .oena(oena), .odat_l(odat_l), .odat_h(odat_h),
    .oavail(oavail), .oovf(oovf), .ounf(ounf), .ocoll(ocoll)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void m_write(input logic [W-1:0] d);
    if (m_avail == D) m_ovf = 1'b1;
    else begin
      m_mem[m_wr] = d;
      m_wr = (m_wr + 1) % D;
      m_avail++;
    end
  endfunction

  // A pair needs S+1 words; a good pair consumes 2S words starting at the base.
  function automatic void m_read(input int lvl, output logic ok, output t_wvlt_pair p);
    int s;
    s = 1 << lvl;
    if (m_avail < s + 1) begin
      ok = 1'b0; p = '0; m_unf = 1'b1;
    end else begin
      ok = 1'b1;
      p.l = m_mem[m_base];
      p.h = m_mem[(m_base + s) % D];
      m_base = (m_base + 2 * s) % D;
      m_avail = (m_avail > 2 * s) ? m_avail - 2 * s : 0;
    end
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr_word(input logic [W-1:0] d);
    iclk_wr = 1'b1; idat = d; m_write(d);
    tick;
    iclk_wr = 1'b0;
    tick;
  endtask

  task automatic start_frame(input int lvl);
    iena = 1'b0; ireq = 1'b0; iclr = 1'b1;
    tick;
    iclr = 1'b0;
    tick;
    ilevel = 2'(lvl); iena = 1'b1; ireq = 1'b1;
    tick;
    ilevel = 2'($urandom);
    m_wr = 0; m_base = 0; m_avail = 0;
    m_ovf = 1'b0; m_unf = 1'b0; m_coll = 1'b0;
  endtask

  task automatic do_read(output int lat, output logic ena, output logic [W-1:0] l,
                         output logic [W-1:0] h);
    lat = -1; ena = 1'b0; l = '0; h = '0;
    iclk_rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (oclk_ena && lat < 0) begin
        lat = k; ena = oena; l = odat_l; h = odat_h;
      end
      tick;
      iclk_rd = 1'b0;
    end
  endtask

  task automatic test_reset;
    irst_n = 1'b0; iclk_wr = 1'b0; iena = 1'b0; iclk_rd = 1'b0; ireq = 1'b0;
    iclr = 1'b0; idat = '0; ilevel = '0;
    repeat (3) tick;
    checks++;
    if ({oclk_ena, oena, odat_l, odat_h, oavail, oovf, ounf, ocoll} !== '0) begin
      failures++;
      $display("FAIL reset_held: outs=%h required 0", {oclk_ena, oena, odat_l, odat_h, oavail, oovf, ounf, ocoll});
    end
    irst_n = 1'b1;
    repeat (2) tick;
    checks++;
    if ({oclk_ena, oena, odat_l, odat_h, oavail, oovf, ounf, ocoll} !== '0) begin
      failures++;
      $display("FAIL reset_released: outs=%h required 0", {oclk_ena, oena, odat_l, odat_h, oavail, oovf, ounf, ocoll});
    end
  endtask

  task automatic test_level0_back_to_back;
    logic e_ok; t_wvlt_pair e; int n;
    start_frame(0);
    for (int i = 0; i < 8; i++) wr_word(16'($urandom));
    n = 0;
    for (int k = 0; k < 20; k++) begin
      iclk_rd = (k % 4 == 0) && (k < 16);
      @(negedge clk);
      if (oclk_ena) begin
        m_read(0, e_ok, e);
        checks++;
        if ({8'(k), oena, odat_l, odat_h} !== {8'(4 * n + 3), e_ok, e.l, e.h}) begin
          failures++;
          $display("FAIL lvl0_pair%0d: cyc=%0d ena=%b l=%h h=%h required cyc=%0d ena=%b l=%h h=%h",
                   n, k, oena, odat_l, odat_h, 4 * n + 3, e_ok, e.l, e.h);
        end
        n++;
      end
      tick;
    end
    iclk_rd = 1'b0;
    checks++;
    if (n != 4) begin failures++; $display("FAIL lvl0_pulses: got %0d required 4", n); end
    checks++;
    if (oavail !== 9'd0) begin failures++; $display("FAIL lvl0_avail: got %0d required 0", oavail); end
  endtask

  task automatic test_level2;
    int lat; logic ena, e_ok; logic [W-1:0] l, h; t_wvlt_pair e;
    start_frame(2);
    for (int i = 0; i < 16; i++) wr_word(16'($urandom));
    checks++;
    if (oavail !== 9'd16) begin failures++; $display("FAIL lvl2_avail_init: got %0d required 16", oavail); end
    for (int r = 0; r < 2; r++) begin
      do_read(lat, ena, l, h);
      m_read(2, e_ok, e);
      checks++;
      if ({8'(lat), ena, l, h} !== {8'd3, e_ok, e.l, e.h}) begin
        failures++;
        $display("FAIL lvl2_pair%0d: lat=%0d ena=%b l=%h h=%h required lat=3 ena=%b l=%h h=%h",
                 r, lat, ena, l, h, e_ok, e.l, e.h);
      end
      checks++;
      if (oavail !== 9'(m_avail)) begin
        failures++; $display("FAIL lvl2_avail%0d: got %0d required %0d", r, oavail, m_avail);
      end
    end
  endtask

  task automatic test_overflow;
    int lat; logic ena, e_ok; logic [W-1:0] l, h, w0; t_wvlt_pair e;
    start_frame(0);
    w0 = 16'($urandom);
    wr_word(w0);
    for (int i = 1; i < 256; i++) wr_word(16'($urandom));
    wr_word(~w0);
    checks++;
    if ({oavail, oovf} !== {9'(m_avail), m_ovf}) begin
      failures++; $display("FAIL ovf_full: avail=%0d ovf=%b required avail=%0d ovf=%b", oavail, oovf, m_avail, m_ovf);
    end
    do_read(lat, ena, l, h);
    m_read(0, e_ok, e);
    checks++;
    if ({ena, l, h} !== {e_ok, e.l, e.h}) begin
      failures++; $display("FAIL ovf_word0: ena=%b l=%h h=%h required ena=%b l=%h h=%h", ena, l, h, e_ok, e.l, e.h);
    end
    iclr = 1'b1; tick; iclr = 1'b0; tick;
    checks++;
    if (oovf !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b required 0", oovf); end
  endtask

  task automatic test_underrun;
    int lat; logic ena, e_ok; logic [W-1:0] l, h; t_wvlt_pair e;
    start_frame(1);
    wr_word(16'($urandom)); wr_word(16'($urandom));
    do_read(lat, ena, l, h);
    m_read(1, e_ok, e);
    checks++;
    if ({8'(lat), ena, l, h, ounf, oavail} !== {8'd3, e_ok, e.l, e.h, m_unf, 9'(m_avail)}) begin
      failures++;
      $display("FAIL unf_bad: lat=%0d ena=%b l=%h h=%h unf=%b avail=%0d required lat=3 ena=%b l=%h h=%h unf=%b avail=%0d",
               lat, ena, l, h, ounf, oavail, e_ok, e.l, e.h, m_unf, m_avail);
    end
    wr_word(16'($urandom));
    do_read(lat, ena, l, h);
    m_read(1, e_ok, e);
    checks++;
    if ({8'(lat), ena, l, h} !== {8'd3, e_ok, e.l, e.h}) begin
      failures++;
      $display("FAIL unf_retry: lat=%0d ena=%b l=%h h=%h required lat=3 ena=%b l=%h h=%h",
               lat, ena, l, h, e_ok, e.l, e.h);
    end
  endtask

  task automatic test_collision;
    logic e_ok; t_wvlt_pair e; int n; logic [W-1:0] d;
    start_frame(0);
    for (int i = 0; i < 8; i++) wr_word(16'($urandom));
    n = 0;
    for (int k = 0; k < 10; k++) begin
      iclk_rd = (k == 0) || (k == 2);
      if (k == 2) m_coll = 1'b1;
      @(negedge clk);
      if (oclk_ena) begin
        n++;
        m_read(0, e_ok, e);
        checks++;
        if ({oena, odat_l, odat_h} !== {e_ok, e.l, e.h}) begin
          failures++; $display("FAIL coll_pair: ena=%b l=%h h=%h required ena=%b l=%h h=%h",
                               oena, odat_l, odat_h, e_ok, e.l, e.h);
        end
      end
      tick;
    end
    iclk_rd = 1'b0;
    checks++;
    if ({8'(n), ocoll, oavail} !== {8'd1, m_coll, 9'(m_avail)}) begin
      failures++; $display("FAIL coll_flags: pulses=%0d coll=%b avail=%0d required pulses=1 coll=%b avail=%0d",
                           n, ocoll, oavail, m_coll, m_avail);
    end
    // write landing on the retire cycle
    start_frame(0);
    for (int i = 0; i < 5; i++) wr_word(16'($urandom));
    d = 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      iclk_rd = (k == 0);
      iclk_wr = (k == 3);
      idat = d;
      if (k == 3) m_write(d);
      @(negedge clk);
      if (oclk_ena) begin
        m_read(0, e_ok, e);
        checks++;
        if ({8'(k), oena, odat_l, odat_h} !== {8'd3, e_ok, e.l, e.h}) begin
          failures++; $display("FAIL same_cycle_pair: cyc=%0d ena=%b l=%h h=%h required cyc=3 ena=%b l=%h h=%h",
                               k, oena, odat_l, odat_h, e_ok, e.l, e.h);
        end
      end
      tick;
    end
    iclk_rd = 1'b0; iclk_wr = 1'b0;
    checks++;
    if (oavail !== 9'd4) begin failures++; $display("FAIL same_cycle_avail: got %0d required 4", oavail); end
  endtask

  task automatic test_reset_mid;
    int lat; logic ena, e_ok; logic [W-1:0] l, h; t_wvlt_pair e;
    start_frame(1);
    for (int i = 0; i < 8; i++) wr_word(16'($urandom));
    do_read(lat, ena, l, h);
    m_read(1, e_ok, e);
    iclk_rd = 1'b1; tick; iclk_rd = 1'b0; tick;
    #1 irst_n = 1'b0;
    #1;
    checks++;
    if ({oclk_ena, oena, odat_l, odat_h, oavail, oovf, ounf, ocoll} !== '0) begin
      failures++;
      $display("FAIL reset_mid: outs=%h required 0", {oclk_ena, oena, odat_l, odat_h, oavail, oovf, ounf, ocoll});
    end
    tick;
    irst_n = 1'b1;
    tick;
    start_frame(3);
    for (int i = 0; i < 16; i++) wr_word(16'($urandom));
    do_read(lat, ena, l, h);
    m_read(3, e_ok, e);
    checks++;
    if ({8'(lat), ena, l, h, oavail} !== {8'd3, e_ok, e.l, e.h, 9'(m_avail)}) begin
      failures++;
      $display("FAIL reset_fresh_lvl3: lat=%0d ena=%b l=%h h=%h avail=%0d required lat=3 ena=%b l=%h h=%h avail=%0d",
               lat, ena, l, h, oavail, e_ok, e.l, e.h, m_avail);
    end
  endtask

  task automatic test_random;
    int lat; logic ena, e_ok; logic [W-1:0] l, h; t_wvlt_pair e;
    for (int f = 0; f < 6; f++) begin
      int lvl; int s;
      lvl = $urandom_range(0, 3);
      s = 1 << lvl;
      start_frame(lvl);
      repeat ($urandom_range(0, 20)) wr_word(16'($urandom));
      for (int r = 0; r < 5; r++) begin
        if (m_avail > s && m_avail < 2 * s) begin
          while (m_avail < 2 * s) wr_word(16'($urandom));
        end
        do_read(lat, ena, l, h);
        m_read(lvl, e_ok, e);
        checks++;
        if ({8'(lat), ena, l, h, oavail, ounf} !== {8'd3, e_ok, e.l, e.h, 9'(m_avail), m_unf}) begin
          failures++;
          $display("FAIL rand_f%0d_r%0d: lat=%0d ena=%b l=%h h=%h avail=%0d unf=%b required lat=3 ena=%b l=%h h=%h avail=%0d unf=%b",
                   f, r, lat, ena, l, h, oavail, ounf, e_ok, e.l, e.h, m_avail, m_unf);
        end
        repeat ($urandom_range(0, 2 * s + 2)) wr_word(16'($urandom));
      end
    end
  endtask

  initial begin
    test_reset;
    test_level0_back_to_back;
    test_level2;
    test_overflow;
    test_underrun;
    test_collision;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
